// File: rtl/mem_arbiter.sv
// Two-requester arbiter/sequencer for the shared word-addressed memory.
// Requester 0 is the core, requester 1 the loader/debug DMA port. Every
// access runs the fixed sequence IDLE -> ACCESS -> RESP and finishes with a
// one-cycle done pulse that carries the read data on the requester's rdata.
module mem_arbiter #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 32,
   parameter bit RR     = 1'b1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_gnt,
   output logic              m0_done,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_gnt,
   output logic              m1_done,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              mem_cs,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t              state_reg;
   logic                owner_reg;   // 0 = requester 0 owns the current transfer
   logic                ptr_reg;     // round-robin preference for the next tie
   logic                we_reg;
   logic [ADDR_W-1:0]   addr_reg;
   logic [DATA_W-1:0]   wdata_reg;

   logic                elig0;
   logic                elig1;
   logic                pick1;

   // A requester is masked during its own done cycle so a held req cannot
   // immediately re-win; ties go to the pointer (RR) or to requester 0.
   always_comb begin
      elig0 = m0_req & ~m0_done;
      elig1 = m1_req & ~m1_done;
      pick1 = elig1 & (~elig0 | (RR ? ptr_reg : 1'b0));
   end

   // Sequencer: grant and latch in IDLE, strobe memory in ACCESS, complete in RESP.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg <= IDLE;
         owner_reg <= 1'b0;
         ptr_reg   <= 1'b0;
         we_reg    <= 1'b0;
         addr_reg  <= '0;
         wdata_reg <= '0;
         m0_gnt    <= 1'b0;
         m1_gnt    <= 1'b0;
         m0_done   <= 1'b0;
         m1_done   <= 1'b0;
         m0_rdata  <= '0;
         m1_rdata  <= '0;
      end else begin
         m0_done <= 1'b0;
         m1_done <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (elig0 | elig1) begin
                  owner_reg <= pick1;
                  we_reg    <= pick1 ? m1_we    : m0_we;
                  addr_reg  <= pick1 ? m1_addr  : m0_addr;
                  wdata_reg <= pick1 ? m1_wdata : m0_wdata;
                  m0_gnt    <= ~pick1;
                  m1_gnt    <= pick1;
                  state_reg <= ACCESS;
               end
            end
            ACCESS: begin
               state_reg <= RESP;
            end
            RESP: begin
               // Memory read data is valid now, one cycle after chip select.
               if (!we_reg) begin
                  if (owner_reg) m1_rdata <= mem_rdata;
                  else           m0_rdata <= mem_rdata;
               end
               m0_done   <= ~owner_reg;
               m1_done   <= owner_reg;
               m0_gnt    <= 1'b0;
               m1_gnt    <= 1'b0;
               ptr_reg   <= ~owner_reg;
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   // Memory strobes exist only in ACCESS, and reset kills them immediately so
   // an interrupted write never reaches the array.
   always_comb begin
      mem_cs    = (state_reg == ACCESS) & ~RST;
      mem_we    = mem_cs & we_reg;
      mem_addr  = addr_reg;
      mem_wdata = wdata_reg;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: one round-robin and one fixed-priority instance,
// each with its own synchronous memory, driven by directed and random
// requester traffic and compared every cycle against a timeline model.
module tb_mem_arbiter;

   logic        CLK;
   logic        RST;

   logic        req_r   [2][2];
   logic        we_r    [2][2];
   logic [6:0]  addr_r  [2][2];
   logic [31:0] wd_r    [2][2];
   wire         gnt_w   [2][2];
   wire         done_w  [2][2];
   wire  [31:0] rd_w    [2][2];
   wire         cs_w    [2];
   wire         mwe_w   [2];
   wire  [6:0]  maddr_w [2];
   wire  [31:0] mwd_w   [2];
   logic [31:0] mrd_r   [2];
   logic [31:0] mem     [2][128];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // instance 0: round-robin, instance 1: fixed priority
   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      mem_arbiter #(.ADDR_W(7), .DATA_W(32), .RR(gi == 0 ? 1'b1 : 1'b0)) dut (
         .CLK(CLK), .RST(RST),
         .m0_req(req_r[gi][0]), .m0_we(we_r[gi][0]), .m0_addr(addr_r[gi][0]),
         .m0_wdata(wd_r[gi][0]), .m0_gnt(gnt_w[gi][0]), .m0_done(done_w[gi][0]),
         .m0_rdata(rd_w[gi][0]),
         .m1_req(req_r[gi][1]), .m1_we(we_r[gi][1]), .m1_addr(addr_r[gi][1]),
         .m1_wdata(wd_r[gi][1]), .m1_gnt(gnt_w[gi][1]), .m1_done(done_w[gi][1]),
         .m1_rdata(rd_w[gi][1]),
         .mem_cs(cs_w[gi]), .mem_we(mwe_w[gi]), .mem_addr(maddr_w[gi]),
         .mem_wdata(mwd_w[gi]), .mem_rdata(mrd_r[gi])
      );
   end

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Synchronous memories: read data appears the cycle after chip select.
   always @(posedge CLK) begin
      for (int d = 0; d < 2; d++) begin
         if (cs_w[d]) begin
            if (mwe_w[d]) mem[d][maddr_w[d]] <= mwd_w[d];
            else          mrd_r[d] <= mem[d][maddr_w[d]];
         end
      end
   end

   // ---------------- reference model (absolute-cycle timeline) -------------
   bit          valid = 1'b0;
   int          acc_cyc  [2];       // cycle in which the memory is strobed
   int          who      [2];       // requester owning that access
   bit          ptr      [2];
   int          done_cyc [2][2];
   bit          done_rd  [2][2];
   bit          acc_we   [2];
   logic [6:0]  acc_addr [2];
   logic [31:0] acc_wd   [2];
   logic [31:0] pend     [2][2];
   logic [31:0] exp_rd   [2][2];
   logic [31:0] shadow   [2][128];
   bit          written  [2][128];
   int          auto_n   [2][2];
   int          auto_mode[2][2];    // 1 = reads of known words, 2 = random mix

   task automatic chk(input string tag, input int d, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s dut%0d cyc%0d observed=%h expected=%h", tag, d, cyc, obs, exp);
      end
   endtask

   task automatic check_outputs();
      for (int d = 0; d < 2; d++) begin
         bit cs_exp;
         for (int r = 0; r < 2; r++) begin
            bit g_exp;
            if (cyc == done_cyc[d][r] && done_rd[d][r]) exp_rd[d][r] = pend[d][r];
            g_exp = (who[d] == r) && (cyc == acc_cyc[d] || cyc == acc_cyc[d] + 1);
            chk($sformatf("gnt%0d", r),   d, 32'(gnt_w[d][r]),  32'(g_exp));
            chk($sformatf("done%0d", r),  d, 32'(done_w[d][r]), 32'(cyc == done_cyc[d][r]));
            chk($sformatf("rdata%0d", r), d, rd_w[d][r], exp_rd[d][r]);
         end
         cs_exp = (cyc == acc_cyc[d]) && !RST;
         chk("mem_cs", d, 32'(cs_w[d]), 32'(cs_exp));
         chk("mem_we", d, 32'(mwe_w[d]), 32'(cs_exp && acc_we[d]));
         if (cs_exp) begin
            chk("mem_addr",  d, 32'(maddr_w[d]), 32'(acc_addr[d]));
            chk("mem_wdata", d, mwd_w[d], acc_wd[d]);
         end
      end
   endtask

   task automatic decide();
      if (RST) begin
         for (int d = 0; d < 2; d++) begin
            acc_cyc[d] = -10; who[d] = 0; ptr[d] = 1'b0;
            for (int r = 0; r < 2; r++) begin
               done_cyc[d][r] = -10; exp_rd[d][r] = '0;
            end
         end
         valid = 1'b1;
      end else begin
         for (int d = 0; d < 2; d++) begin
            if (cyc == acc_cyc[d]) begin
               if (acc_we[d]) shadow[d][acc_addr[d]] = acc_wd[d];
               else           pend[d][who[d]] = shadow[d][acc_addr[d]];
            end
            if (cyc > acc_cyc[d] + 1) begin
               bit e0, e1;
               int w;
               e0 = req_r[d][0] && (cyc != done_cyc[d][0]);
               e1 = req_r[d][1] && (cyc != done_cyc[d][1]);
               if (e0 || e1) begin
                  if (e0 && e1) w = (d == 0) ? int'(ptr[d]) : 0;
                  else          w = e1 ? 1 : 0;
                  who[d]         = w;
                  acc_cyc[d]     = cyc + 1;
                  done_cyc[d][w] = cyc + 3;
                  done_rd[d][w]  = !we_r[d][w];
                  acc_we[d]      = we_r[d][w];
                  acc_addr[d]    = addr_r[d][w];
                  acc_wd[d]      = wd_r[d][w];
                  ptr[d]         = (w == 0);
               end
            end
         end
      end
   endtask

   // One clock: check this cycle's outputs, advance the model, move on.
   task automatic tick();
      #1;
      if (valid) check_outputs();
      decide();
      @(negedge CLK);
      cyc++;
   endtask

   // ---------------- requester drivers ----------------
   task automatic issue(input int d, input int r, input bit w, input logic [6:0] a,
                        input logic [31:0] v);
      req_r[d][r] = 1'b1; we_r[d][r] = w; addr_r[d][r] = a; wd_r[d][r] = v;
      if (w) written[d][a] = 1'b1;
   endtask

   task automatic gen(input int d, input int r);
      logic [6:0] pool [3];
      logic [6:0] a;
      bit         w;
      pool[0] = 7'h05; pool[1] = 7'h7F; pool[2] = 7'h10;
      if (auto_mode[d][r] == 1) begin
         a = pool[$urandom_range(0, 2)];
         w = 1'b0;
      end else begin
         a = ($urandom_range(0, 3) == 0) ? 7'h7F : 7'($urandom_range(0, 7));
         w = ($urandom_range(0, 1) == 1) || !written[d][a];
      end
      issue(d, r, w, a, $urandom);
   endtask

   // In the done cycle either re-present a new request or drop req.
   task automatic drive();
      for (int d = 0; d < 2; d++) begin
         for (int r = 0; r < 2; r++) begin
            if (cyc == done_cyc[d][r]) begin
               if (auto_n[d][r] > 0) begin gen(d, r); auto_n[d][r]--; end
               else req_r[d][r] = 1'b0;
            end else if (!req_r[d][r] && auto_n[d][r] > 0 && auto_mode[d][r] == 2
                         && $urandom_range(0, 2) == 0) begin
               gen(d, r); auto_n[d][r]--;
            end
         end
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         drive();
         tick();
      end
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         acc_cyc[d] = -10; who[d] = 0; ptr[d] = 1'b0;
         acc_we[d] = 1'b0; acc_addr[d] = '0; acc_wd[d] = '0;
         for (int r = 0; r < 2; r++) begin
            req_r[d][r] = 1'b0; we_r[d][r] = 1'b0; addr_r[d][r] = '0; wd_r[d][r] = '0;
            done_cyc[d][r] = -10; done_rd[d][r] = 1'b0; auto_n[d][r] = 0;
            auto_mode[d][r] = 2; pend[d][r] = '0; exp_rd[d][r] = '0;
         end
         for (int a = 0; a < 128; a++) begin
            written[d][a] = 1'b0; shadow[d][a] = '0;
         end
      end
      RST = 1'b1;
      @(negedge CLK);

      // Reset with both requesting (writes that preload the memories)
      for (int d = 0; d < 2; d++) begin
         issue(d, 0, 1'b1, 7'h05, 32'hDEADBEEF);
         issue(d, 1, 1'b1, 7'h10, 32'h55555555);
      end
      run(2);
      RST = 1'b0;
      run(12);

      // Single read with latency check
      for (int d = 0; d < 2; d++) issue(d, 0, 1'b0, 7'h05, 32'h0);
      run(6);

      // Write to the top word, then read it back from the other requester
      for (int d = 0; d < 2; d++) issue(d, 1, 1'b1, 7'h7F, 32'h12345678);
      run(5);
      for (int d = 0; d < 2; d++) issue(d, 0, 1'b0, 7'h7F, 32'h0);
      run(5);

      // Continuous reads from both, six transfers total
      for (int d = 0; d < 2; d++) begin
         for (int r = 0; r < 2; r++) begin
            auto_mode[d][r] = 1; auto_n[d][r] = 2;
            gen(d, r);
         end
      end
      run(30);

      // Pointer now favours requester 1 after an m0 transfer; raise both together
      for (int d = 0; d < 2; d++) issue(d, 0, 1'b0, 7'h05, 32'h0);
      run(5);
      for (int d = 0; d < 2; d++) begin
         issue(d, 0, 1'b0, 7'h7F, 32'h0);
         issue(d, 1, 1'b0, 7'h05, 32'h0);
      end
      run(10);
      for (int d = 0; d < 2; d++) issue(d, 1, 1'b0, 7'h10, 32'h0);
      run(5);

      // Reset during the ACCESS cycle of a write
      for (int d = 0; d < 2; d++) issue(d, 1, 1'b1, 7'h10, 32'hAAAAAAAA);
      run(1);
      RST = 1'b1;
      for (int d = 0; d < 2; d++) req_r[d][1] = 1'b0;
      run(1);
      RST = 1'b0;
      run(2);
      for (int d = 0; d < 2; d++) issue(d, 0, 1'b0, 7'h10, 32'h0);
      run(5);
      for (int d = 0; d < 2; d++) chk("mem10_kept", d, rd_w[d][0], 32'h55555555);

      // Random mixed traffic from both requesters
      for (int d = 0; d < 2; d++) begin
         for (int r = 0; r < 2; r++) begin
            auto_mode[d][r] = 2; auto_n[d][r] = 20;
         end
      end
      run(300);
      for (int d = 0; d < 2; d++) begin
         for (int r = 0; r < 2; r++) auto_n[d][r] = 0;
      end
      run(12);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
